// File: rtl/ej32_pkg.sv
// ---------------------------------------------------------------------------
// ej32_pkg : shared types and requester indices for the EJ32 memory arbiter
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ej32_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int RQ_FETCH = 0;
    localparam int RQ_LS    = 1;
    localparam int RQ_IO    = 2;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ej32_rr_pick.sv
// ---------------------------------------------------------------------------
// ej32_rr_pick : combinational round-robin picker, searches upward from last+1
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ej32_rr_pick
    import ej32_pkg::*;
#(
    parameter int NRQ = 3,
    parameter int LW  = idx_w(NRQ)
) (
    input  logic [NRQ-1:0] req,
    input  logic [LW-1:0]  last,
    output logic [NRQ-1:0] pick,
    output logic [LW-1:0]  idx,
    output logic           any
);

    logic [LW-1:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NRQ; k++) begin
            cand = LW'((int'(last) + k) % NRQ);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ej32_mem_arb.sv
// ---------------------------------------------------------------------------
// ej32_mem_arb : round-robin byte-SRAM arbiter with bounded locked bursts
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ej32_mem_arb
    import ej32_pkg::*;
#(
    parameter int ASZ     = 17,
    parameter int NRQ     = 3,
    parameter int MAXHOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NRQ-1:0]     req,
    input  logic [NRQ-1:0]     lock,
    input  logic [NRQ*ASZ-1:0] addr,
    input  logic [NRQ-1:0]     we,
    input  logic [NRQ*8-1:0]   wd,
    output logic [NRQ-1:0]     gnt,
    output logic [NRQ-1:0]     rvld,
    output logic [7:0]         rd,
    output logic [ASZ-1:0]     mem_a,
    output logic               mem_we,
    output logic [7:0]         mem_wd,
    input  logic [7:0]         mem_rd,
    output logic               ovf
);

    localparam int LW = idx_w(NRQ);
    localparam int CW = $clog2(MAXHOLD) + 1;

    arb_state_t     state;
    logic [LW-1:0]  owner;
    logic [LW-1:0]  last;
    logic [CW-1:0]  cnt;
    logic [NRQ-1:0] pick;
    logic [LW-1:0]  pick_idx;
    logic           pick_any;
    logic [LW-1:0]  sel;

    ej32_rr_pick #(
        .NRQ (NRQ),
        .LW  (LW)
    ) u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Grants are combinational so the access completes in the request cycle.
    always_comb begin
        gnt = '0;
        sel = pick_idx;
        ovf = 1'b0;
        if (!rst) begin
            if (state == ARB_IDLE) begin
                gnt = pick;
            end else begin
                sel = owner;
                if (req[owner]) begin
                    gnt[owner] = 1'b1;
                    ovf        = (cnt == CW'(MAXHOLD - 1));
                end
            end
        end
    end

    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        if (|gnt) begin
            mem_a  = addr[int'(sel)*ASZ +: ASZ];
            mem_we = we[sel];
            mem_wd = wd[int'(sel)*8 +: 8];
        end
    end

    assign rd = mem_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= '0;
            last  <= LW'(NRQ - 1);
            cnt   <= '0;
            rvld  <= '0;
        end else begin
            rvld <= gnt & ~we;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        last <= pick_idx;
                        if (lock[pick_idx]) begin
                            state <= ARB_LOCK;
                            owner <= pick_idx;
                            cnt   <= CW'(1);
                        end
                    end
                end
                ARB_LOCK: begin
                    // last already equals owner, so a broken lock yields priority.
                    if (!req[owner] || !lock[owner] || cnt == CW'(MAXHOLD - 1)) begin
                        state <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ej32_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_ej32_mem_arb : directed and random checks of ej32_mem_arb against a model
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ej32_mem_arb;

    localparam int ASZ     = 17;
    localparam int NRQ     = 3;
    localparam int MAXHOLD = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NRQ-1:0]     req;
    logic [NRQ-1:0]     lock;
    logic [NRQ*ASZ-1:0] addr;
    logic [NRQ-1:0]     we;
    logic [NRQ*8-1:0]   wd;
    logic [NRQ-1:0]     gnt;
    logic [NRQ-1:0]     rvld;
    logic [7:0]         rd;
    logic [ASZ-1:0]     mem_a;
    logic               mem_we;
    logic [7:0]         mem_wd;
    logic [7:0]         mem_rd;
    logic               ovf;

    ej32_mem_arb #(
        .ASZ     (ASZ),
        .NRQ     (NRQ),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .gnt    (gnt),
        .rvld   (rvld),
        .rd     (rd),
        .mem_a  (mem_a),
        .mem_we (mem_we),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read byte SRAM
    logic [7:0] sram [0:(1<<ASZ)-1];
    initial begin
        for (int i = 0; i < (1 << ASZ); i++) sram[i] = 8'(i) ^ 8'(i >> 8);
    end
    always @(posedge clk) begin
        if (mem_we) sram[mem_a] <= mem_wd;
        mem_rd <= sram[mem_a];
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: burst tracked as "bytes granted so far"
    bit         m_burst;
    int         m_owner;
    int         m_last;
    int         m_nb;
    logic [7:0] m_mem [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ASZ-1:0] addr_of(input int w);
        return addr[w*ASZ +: ASZ];
    endfunction

    function automatic logic [7:0] mem_val(input logic [ASZ-1:0] a);
        if (m_mem.exists(int'(a))) return m_mem[int'(a)];
        return a[7:0] ^ {1'b0, a[ASZ-1:8]};
    endfunction

    task automatic set_rq(input int i, input logic [ASZ-1:0] a, input logic w, input logic [7:0] d);
        addr[i*ASZ +: ASZ] = a;
        we[i]              = w;
        wd[i*8 +: 8]       = d;
    endtask

    // One arbitration cycle: entered at posedge+1 with inputs already set.
    task automatic tick(input int lit_gnt, input int lit_ovf);
        int             w;
        bit             eovf;
        logic [NRQ-1:0] eg;
        logic [NRQ-1:0] nrvld;
        logic [7:0]     nrd;
        #1;
        w    = -1;
        eovf = 1'b0;
        if (!m_burst) begin
            for (int k = 1; k <= NRQ; k++) begin
                if (w < 0 && req[(m_last + k) % NRQ]) w = (m_last + k) % NRQ;
            end
            if (w >= 0) begin
                m_last = w;
                if (lock[w]) begin
                    m_burst = 1'b1;
                    m_owner = w;
                    m_nb    = 1;
                end
            end
        end else if (req[m_owner]) begin
            w = m_owner;
            m_nb++;
            if (m_nb == MAXHOLD) begin
                eovf    = 1'b1;
                m_burst = 1'b0;
            end else if (!lock[w]) begin
                m_burst = 1'b0;
            end
        end else begin
            m_burst = 1'b0;
        end
        eg = (w >= 0) ? NRQ'(1 << w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("ovf", 32'(ovf), 32'(eovf));
        chk("mem_a", 32'(mem_a), (w >= 0) ? 32'(addr_of(w)) : 32'd0);
        chk("mem_we", 32'(mem_we), (w >= 0) ? 32'(we[w]) : 32'd0);
        chk("mem_wd", 32'(mem_wd), (w >= 0) ? 32'(wd[w*8 +: 8]) : 32'd0);
        if (lit_gnt >= 0) chk("lit_gnt", 32'(gnt), 32'(lit_gnt));
        if (lit_ovf >= 0) chk("lit_ovf", 32'(ovf), 32'(lit_ovf));
        nrvld = (w >= 0 && !we[w]) ? eg : '0;
        nrd   = (w >= 0) ? mem_val(addr_of(w)) : 8'h00;
        if (w >= 0 && we[w]) m_mem[int'(addr_of(w))] = wd[w*8 +: 8];
        @(posedge clk);
        #1;
        chk("rvld", 32'(rvld), 32'(nrvld));
        if (nrvld != '0) chk("rd", 32'(rd), 32'(nrd));
    endtask

    // Assert reset mid-cycle, check the outputs collapse at once, release after an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rvld", 32'(rvld), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        m_burst = 1'b0;
        m_last  = NRQ - 1;
        m_nb    = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        addr = '0;
        we   = '0;
        wd   = '0;
        do_reset();

        // Round robin from reset: 0,1,2,0
        req = 3'b111;
        tick(1, -1); tick(2, -1); tick(4, -1); tick(1, -1);

        // Requester 1 reads a locked 4-byte burst while requester 0 waits
        req  = 3'b011;
        lock = 3'b010;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) lock = 3'b000;
            set_rq(1, ASZ'(32'h1000 + i), 1'b0, 8'h00);
            tick(2, 0);
        end
        req = 3'b001;
        tick(1, -1);

        // Requester 2 writes 0x41 to 0x1400
        req = 3'b100;
        set_rq(2, ASZ'(32'h1400), 1'b1, 8'h41);
        #1;
        chk("w41_mem_a", 32'(mem_a), 32'h1400);
        chk("w41_mem_we", 32'(mem_we), 32'd1);
        chk("w41_mem_wd", 32'(mem_wd), 32'h41);
        tick(4, 0);
        chk("w41_rvld", 32'(rvld), 32'd0);
        we = '0;

        // Lock held past the limit: 8 grants, ovf on the 8th, then requester 2
        req  = 3'b110;
        lock = 3'b010;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8)       tick(2, (c == 8) ? 1 : 0);
            else if (c == 9)  tick(4, 0);
            else              tick(-1, -1);
        end
        do_reset();

        // Reset in the second cycle of a locked burst
        req  = 3'b001;
        lock = 3'b001;
        tick(1, 0);
        do_reset();
        req  = 3'b111;
        lock = 3'b000;
        tick(1, -1);

        // Owner drops req while locked: one dead cycle, then round robin
        req  = 3'b010;
        lock = 3'b010;
        tick(2, 0);
        req  = 3'b101;
        lock = 3'b000;
        tick(0, 0);
        tick(4, -1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < NRQ; i++) begin
                    req[i]  = ($urandom_range(0, 3) != 0);
                    lock[i] = ($urandom_range(0, 4) != 0);
                    set_rq(i, ASZ'(32'h1000 + $urandom_range(0, 15)),
                           ($urandom_range(0, 9) < 3), 8'($urandom));
                end
                tick(-1, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ej32_mem_arb.md
EJ32_MEM_ARB -- requirements
Module: ej32_mem_arb

Interface
REQ-001 Parameter ASZ, default 17, memory address width (128K space).
REQ-002 Parameter NRQ, default 3, requester count (0 fetch, 1 load/store, 2 console I/O).
REQ-003 Parameter MAXHOLD, default 8, maximum consecutive locked grants.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req  in  NRQ  per-requester access request.
REQ-007 lock  in  NRQ  per-requester hold-bus request for multi-byte bursts.
REQ-008 addr  in  NRQ*ASZ  per-requester byte address.
REQ-009 we  in  NRQ  per-requester write enable.
REQ-010 wd  in  NRQ*8  per-requester write byte.
REQ-011 gnt  out  NRQ  one-hot grant; the access completes in the cycle it is asserted.
REQ-012 rvld  out  NRQ  read data valid, one cycle after a granted read.
REQ-013 rd  out  8  read byte returned to requesters.
REQ-014 mem_a  out  ASZ  SRAM address.
REQ-015 mem_we  out  1  SRAM write strobe.
REQ-016 mem_wd  out  8  SRAM write byte.
REQ-017 mem_rd  in  8  SRAM read byte, valid one cycle after the address.
REQ-018 ovf  out  1  one-cycle pulse when a lock is forcibly broken.

Function
REQ-019 FSM states: ARB_IDLE and ARB_LOCK; owner register, log2(NRQ) bits; round-robin pointer last, log2(NRQ) bits; hold counter cnt, log2(MAXHOLD)+1 bits.
REQ-020 ARB_IDLE: the winner is the first asserted req searched from last+1 upward, modulo NRQ; gnt[winner] is asserted combinationally in the same cycle; last <= winner.
REQ-021 ARB_IDLE with winner lock=1: next state is ARB_LOCK, owner <= winner, cnt <= 1.
REQ-022 ARB_LOCK: only owner is eligible; other requests wait with gnt=0.
REQ-023 ARB_LOCK with req[owner]=1 and lock[owner]=1: grant owner, cnt++, stay in ARB_LOCK.
REQ-024 ARB_LOCK with req[owner]=1 and lock[owner]=0: grant owner (final byte), then return to ARB_IDLE.
REQ-025 ARB_LOCK with req[owner]=0: no grant this cycle, return to ARB_IDLE (one dead cycle).
REQ-026 On a grant in ARB_LOCK with cnt = MAXHOLD-1: pulse ovf and force ARB_IDLE; last stays at owner, so the owner loses priority.
REQ-027 Bus mux: mem_a, mem_we and mem_wd come from the granted requester; with no grant, mem_a=0, mem_we=0, mem_wd=0.
REQ-028 mem_we = we of the granted requester.
REQ-029 rvld is registered: rvld[i] <= gnt[i] & ~we[i].
REQ-030 rd = mem_rd passthrough.
REQ-031 gnt is never asserted for a requester whose req=0.
REQ-032 gnt is always zero- or one-hot.
REQ-033 Pointer wrap: last = NRQ-1 searches from 0.

Reset
REQ-034 Asynchronous reset sets: state ARB_IDLE, owner=0, last=NRQ-1 (requester 0 wins first), cnt=0, rvld=0, ovf=0.
REQ-035 While rst is high, gnt=0 and mem_we=0.
REQ-036 Reset during ARB_LOCK abandons the burst; no rvld is produced for the interrupted cycle.

Structure
REQ-037 Shared package ej32_pkg holds arb_state_t {ARB_IDLE, ARB_LOCK} and the requester index constants RQ_FETCH=0, RQ_LS=1, RQ_IO=2.
REQ-038 One sub-module, ej32_rr_pick: a combinational round-robin priority picker with inputs req and last, and outputs a one-hot pick plus its index.

Verification
REQ-039 After reset, req=3'b111, no lock -> grants in order 0,1,2,0 on consecutive cycles.
REQ-040 Requester 1 reads a 4-byte burst at 0x1000..0x1003 with lock high for 3 cycles while req[0]=1 -> gnt[1] for 4 consecutive cycles, rvld[1] on cycles 2-5, then gnt[0].
REQ-041 Requester 2 writes 0x41 to 0x1400 -> mem_we=1, mem_a=0x1400, mem_wd=0x41 in the grant cycle; no rvld.
REQ-042 Requester 1 holds lock for 10 cycles with req[2]=1 -> 8 grants, ovf pulse on the 8th, gnt[2] on the next cycle.
REQ-043 Assert rst in the 2nd cycle of a locked burst -> gnt=0 and rvld=0 immediately; the first grant after release goes to requester 0.
REQ-044 Owner drops req while locked -> one dead cycle, then normal round-robin resumes.
